fill_rect_word_gen: RTL and testbench

- Parametrised successor of the fill-rectangle data generator in the graphics engine pipeline.
- Accepts one rectangle command per handshake and emits word-merged, per-colour-plane writes to the memory arbiter.
  - Solid fill mode: every pixel of the rectangle.
  - Outline mode: border pixels only.
- Adds a bit-exact lane mask, so neighbouring sub-byte pixels are never clobbered.
- Advances only on real arbiter transfers.

---
 rtl/fill_rect_word_gen_pkg.sv | 35 +++
 rtl/fill_rect_word_gen_if.sv | 54 +++++
 rtl/fill_rect_word_gen_lane_mask.sv | 45 ++++
 rtl/fill_rect_word_gen.sv | 191 +++++++++++++++++++
 tb/tb_fill_rect_word_gen.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/fill_rect_word_gen_pkg.sv
// ============================================================================
//  Module   : fill_rect_pkg
//  Brief    : Shared types and constants for the fill-rectangle word generator.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fill_rect_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    localparam logic MODE_FILL    = 1'b0;
    localparam logic MODE_OUTLINE = 1'b1;

    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_DIM_W       = 16;
    localparam int DEF_CH_BITS     = 4;
    localparam int DEF_NUM_CH      = 3;
    localparam int DEF_LINE_STRIDE = 240;

    localparam int P = 32 / DEF_CH_BITS;

    // Width of the in-word pixel offset; kept at least 1 bit for one-pixel words.
    function automatic int x0_width(input int ch_bits);
        int p;
        p = 32 / ch_bits;
        return (p > 1) ? $clog2(p) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fill_rect_word_gen_if.sv
// ============================================================================
//  Module   : fill_rect_word_gen_if
//  Brief    : Command and arbiter-write bundle of the fill-rectangle generator.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fill_rect_word_gen_if
    import fill_rect_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DIM_W   = DEF_DIM_W,
    parameter int CH_BITS = DEF_CH_BITS,
    parameter int NUM_CH  = DEF_NUM_CH
) ();

    localparam int X0_W = x0_width(CH_BITS);

    logic                        in_rts;
    logic                        out_rtr;
    logic [ADDR_W-1:0]           cmd_addr;
    logic [X0_W-1:0]             cmd_x0;
    logic [DIM_W-1:0]            cmd_wid;
    logic [DIM_W-1:0]            cmd_hgt;
    logic [NUM_CH*CH_BITS-1:0]   cmd_color;
    logic                        cmd_mode;

    logic                        arb_out_rts;
    logic                        arb_in_rtr;
    logic [ADDR_W-1:0]           arb_out_addr;
    logic [31:0]                 arb_out_data;
    logic [31:0]                 arb_out_bmask;
    logic [3:0]                  arb_out_wben;
    logic                        arb_out_op;

    modport slave (
        input  in_rts, cmd_addr, cmd_x0, cmd_wid, cmd_hgt, cmd_color, cmd_mode,
        input  arb_in_rtr,
        output out_rtr,
        output arb_out_rts, arb_out_addr, arb_out_data, arb_out_bmask,
        output arb_out_wben, arb_out_op
    );

    modport master (
        output in_rts, cmd_addr, cmd_x0, cmd_wid, cmd_hgt, cmd_color, cmd_mode,
        output arb_in_rtr,
        input  out_rtr,
        input  arb_out_rts, arb_out_addr, arb_out_data, arb_out_bmask,
        input  arb_out_wben, arb_out_op
    );

endinterface

`default_nettype wire

// File: rtl/fill_rect_word_gen_lane_mask.sv
// ============================================================================
//  Module   : fill_rect_lane_mask
//  Brief    : Combinational bit mask of the pixel lanes written in one word.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fill_rect_lane_mask
    import fill_rect_pkg::*;
#(
    parameter int DIM_W   = DEF_DIM_W,
    parameter int CH_BITS = DEF_CH_BITS
) (
    input  wire logic [DIM_W:0]                 i_word,
    input  wire logic [x0_width(CH_BITS)-1:0]   i_x0,
    input  wire logic [DIM_W-1:0]               i_wid,
    input  wire logic                           i_mode,
    input  wire logic                           i_edge_row,
    output logic [31:0]                         o_bmask
);

    localparam int PW    = 32 / CH_BITS;
    localparam int LOG2P = $clog2(PW);

    logic [DIM_W:0] w_first;
    logic [DIM_W:0] w_last;

    // One extra bit keeps x0+wid-1 exact at the largest width.
    assign w_first = (DIM_W+1)'(i_x0);
    assign w_last  = w_first + (DIM_W+1)'(i_wid) - (DIM_W+1)'(1);

    for (genvar l = 0; l < PW; l++) begin : g_lane
        logic [DIM_W:0] w_p;
        logic           w_on;

        assign w_p  = (i_word << LOG2P) + (DIM_W+1)'(l);
        assign w_on = (i_mode == MODE_OUTLINE && !i_edge_row)
                    ? (w_p == w_first || w_p == w_last)
                    : (w_p >= w_first && w_p <= w_last);
        assign o_bmask[l*CH_BITS +: CH_BITS] = {CH_BITS{w_on}};
    end

endmodule

`default_nettype wire

// File: rtl/fill_rect_word_gen.sv
// ============================================================================
//  Module   : fill_rect_word_gen
//  Brief    : Turns rectangle commands into masked per-plane arbiter writes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fill_rect_word_gen
    import fill_rect_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DIM_W       = DEF_DIM_W,
    parameter int CH_BITS     = DEF_CH_BITS,
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int LINE_STRIDE = DEF_LINE_STRIDE
) (
    input  wire logic           clk,
    input  wire logic           rst_,
    fill_rect_word_gen_if.slave bus
);

    localparam int PW    = 32 / CH_BITS;
    localparam int LOG2P = $clog2(PW);
    localparam int X0_W  = x0_width(CH_BITS);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int COL_W = NUM_CH * CH_BITS;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     row_base_q, row_base_d;
    logic [X0_W-1:0]       x0_q, x0_d;
    logic [DIM_W-1:0]      wid_q, wid_d, hgt_q, hgt_d, row_q, row_d;
    logic [DIM_W:0]        word_q, word_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [COL_W-1:0]      color_q, color_d;
    logic                  mode_q, mode_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [31:0]           data_q, data_d, bmask_q, bmask_d;
    logic [3:0]            wben_q, wben_d;
    logic                  op_q, op_d;

    logic [31:0]           w_lane_mask;
    logic [3:0]            w_wben;
    logic [CH_BITS-1:0]    w_chan;
    logic [DIM_W:0]        w_last_word;
    logic                  w_mid_q, w_mid_d;

    function automatic logic is_middle(input logic mode, input logic [DIM_W-1:0] wid,
                                       input logic [DIM_W-1:0] hgt, input logic [DIM_W-1:0] row);
        return (mode == MODE_OUTLINE) && (wid > DIM_W'(2)) && (hgt > DIM_W'(2)) &&
               (row != '0) && (row != hgt - DIM_W'(1));
    endfunction

    assign w_last_word = ((DIM_W+1)'(x0_q) + (DIM_W+1)'(wid_q) - (DIM_W+1)'(1)) >> LOG2P;
    assign w_mid_q     = is_middle(mode_q, wid_q, hgt_q, row_q);
    assign w_mid_d     = is_middle(mode_d, wid_d, hgt_d, row_d);

    // Position advance: channel fastest, then word, then row.
    always_comb begin
        state_d    = state_q;
        row_base_d = row_base_q;
        x0_d       = x0_q;
        wid_d      = wid_q;
        hgt_d      = hgt_q;
        row_d      = row_q;
        word_d     = word_q;
        ch_d       = ch_q;
        color_d    = color_q;
        mode_d     = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_rts) begin
                    x0_d       = bus.cmd_x0;
                    wid_d      = bus.cmd_wid;
                    hgt_d      = bus.cmd_hgt;
                    color_d    = bus.cmd_color;
                    mode_d     = bus.cmd_mode;
                    row_base_d = bus.cmd_addr;
                    row_d      = '0;
                    word_d     = '0;
                    ch_d       = '0;
                    if (bus.cmd_wid != '0 && bus.cmd_hgt != '0) begin
                        state_d = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: begin
                if (bus.arb_in_rtr) begin
                    if (ch_q != CH_W'(NUM_CH - 1)) begin
                        ch_d = ch_q + CH_W'(1);
                    end else begin
                        ch_d = '0;
                        if (word_q != w_last_word) begin
                            // Middle outline rows jump straight from the left edge word to the right one.
                            word_d = w_mid_q ? w_last_word : word_q + (DIM_W+1)'(1);
                        end else begin
                            word_d = '0;
                            if (row_q == hgt_q - DIM_W'(1)) begin
                                state_d = ST_IDLE;
                            end else begin
                                row_d      = row_q + DIM_W'(1);
                                row_base_d = row_base_q + ADDR_W'(LINE_STRIDE);
                            end
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    fill_rect_lane_mask #(
        .DIM_W   (DIM_W),
        .CH_BITS (CH_BITS)
    ) u_lane_mask (
        .i_word     (word_d),
        .i_x0       (x0_d),
        .i_wid      (wid_d),
        .i_mode     (mode_d),
        .i_edge_row (!w_mid_d),
        .o_bmask    (w_lane_mask)
    );

    for (genvar b = 0; b < 4; b++) begin : g_wben
        assign w_wben[b] = |w_lane_mask[b*8 +: 8];
    end

    assign w_chan = color_d[ch_d*CH_BITS +: CH_BITS];

    // Output registers are loaded from the upcoming position, so they hold while rtr is low.
    always_comb begin
        addr_d  = '0;
        data_d  = '0;
        bmask_d = '0;
        wben_d  = '0;
        op_d    = 1'b0;
        if (state_d == ST_DRIVE) begin
            addr_d  = row_base_d + ADDR_W'(word_d) * ADDR_W'(NUM_CH) + ADDR_W'(ch_d);
            bmask_d = w_lane_mask;
            data_d  = {PW{w_chan}} & w_lane_mask;
            wben_d  = w_wben;
            op_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= ST_IDLE;
            row_base_q <= '0;
            x0_q       <= '0;
            wid_q      <= '0;
            hgt_q      <= '0;
            row_q      <= '0;
            word_q     <= '0;
            ch_q       <= '0;
            color_q    <= '0;
            mode_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            bmask_q    <= '0;
            wben_q     <= '0;
            op_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_base_q <= row_base_d;
            x0_q       <= x0_d;
            wid_q      <= wid_d;
            hgt_q      <= hgt_d;
            row_q      <= row_d;
            word_q     <= word_d;
            ch_q       <= ch_d;
            color_q    <= color_d;
            mode_q     <= mode_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            bmask_q    <= bmask_d;
            wben_q     <= wben_d;
            op_q       <= op_d;
        end
    end

    assign bus.out_rtr       = (state_q == ST_IDLE);
    assign bus.arb_out_rts   = (state_q == ST_DRIVE);
    assign bus.arb_out_addr  = addr_q;
    assign bus.arb_out_data  = data_q;
    assign bus.arb_out_bmask = bmask_q;
    assign bus.arb_out_wben  = wben_q;
    assign bus.arb_out_op    = op_q;

endmodule

`default_nettype wire

// File: tb/tb_fill_rect_word_gen.sv
// ============================================================================
//  Module   : tb_fill_rect_word_gen
//  Brief    : Directed self-checking bench for fill_rect_word_gen.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fill_rect_word_gen;

    logic clk = 1'b0;
    logic rst_;

    always #5 clk = ~clk;

    fill_rect_word_gen_if #(.ADDR_W(16), .DIM_W(16), .CH_BITS(4), .NUM_CH(3)) bus ();

    fill_rect_word_gen #(
        .ADDR_W(16), .DIM_W(16), .CH_BITS(4), .NUM_CH(3), .LINE_STRIDE(240)
    ) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] e_addr[$], e_bm[$], e_dat[$];
    logic [31:0] g_addr[$], g_bm[$], g_dat[$], g_wb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] wben_of(input logic [31:0] m);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) r[b] = |m[b*8 +: 8];
        return r;
    endfunction

    // Three planes of one word: red 0xA, green 0x5, blue 0xF replicated then masked.
    task automatic add_word(input logic [15:0] base, input logic [31:0] bm);
        e_addr.push_back(32'(base));                e_bm.push_back(bm); e_dat.push_back(32'hAAAAAAAA & bm);
        e_addr.push_back(32'(base + 16'd1));        e_bm.push_back(bm); e_dat.push_back(32'h55555555 & bm);
        e_addr.push_back(32'(base + 16'd2));        e_bm.push_back(bm); e_dat.push_back(32'hFFFFFFFF & bm);
    endtask

    task automatic clear_all();
        e_addr.delete(); e_bm.delete(); e_dat.delete();
        g_addr.delete(); g_bm.delete(); g_dat.delete(); g_wb.delete();
    endtask

    task automatic run_cmd(input logic [15:0] a, input logic [2:0] x0, input logic [15:0] wid,
                           input logic [15:0] hgt, input logic mode, input int stall_len,
                           input int abort_at, output int cyc);
        int  stall_left;
        bit  done;
        @(negedge clk);
        chk("accept_rdy", 32'(bus.out_rtr), 32'd1);
        bus.in_rts    = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_x0    = x0;
        bus.cmd_wid   = wid;
        bus.cmd_hgt   = hgt;
        bus.cmd_color = 12'hF5A;
        bus.cmd_mode  = mode;
        @(posedge clk);
        #1 bus.in_rts = 1'b0;
        cyc        = 0;
        stall_left = stall_len;
        done       = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (abort_at > 0 && g_addr.size() == abort_at) return;
            if (bus.out_rtr) begin
                done = 1'b1;
                break;
            end
            cyc++;
            bus.arb_in_rtr = 1'b1;
            if (stall_left > 0 && g_addr.size() == 2) begin
                bus.arb_in_rtr = 1'b0;
                stall_left--;
                chk("stall_rts",  32'(bus.arb_out_rts),  32'd1);
                chk("stall_addr", 32'(bus.arb_out_addr), 32'h0102);
                chk("stall_data", bus.arb_out_data,      32'hFF000000);
            end
            if (bus.arb_out_rts && bus.arb_in_rtr) begin
                g_addr.push_back(32'(bus.arb_out_addr));
                g_bm.push_back(bus.arb_out_bmask);
                g_dat.push_back(bus.arb_out_data);
                g_wb.push_back(32'(bus.arb_out_wben));
                chk("op", 32'(bus.arb_out_op), 32'd1);
            end
        end
        chk("completion", 32'(done), 32'd1);
    endtask

    task automatic compare(input string name);
        chk({name, ".count"}, 32'(g_addr.size()), 32'(e_addr.size()));
        for (int i = 0; i < e_addr.size() && i < g_addr.size(); i++) begin
            chk($sformatf("%s[%0d].addr", name, i),  g_addr[i], e_addr[i]);
            chk($sformatf("%s[%0d].bmask", name, i), g_bm[i],   e_bm[i]);
            chk($sformatf("%s[%0d].data", name, i),  g_dat[i],  e_dat[i]);
            chk($sformatf("%s[%0d].wben", name, i),  g_wb[i],   wben_of(e_bm[i]));
        end
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, ".rtr"},   32'(bus.out_rtr),       32'd1);
        chk({name, ".rts"},   32'(bus.arb_out_rts),   32'd0);
        chk({name, ".addr"},  32'(bus.arb_out_addr),  32'd0);
        chk({name, ".data"},  bus.arb_out_data,       32'd0);
        chk({name, ".bmask"}, bus.arb_out_bmask,      32'd0);
        chk({name, ".wben"},  32'(bus.arb_out_wben),  32'd0);
        chk({name, ".op"},    32'(bus.arb_out_op),    32'd0);
    endtask

    initial begin
        int cyc;
        bus.in_rts     = 1'b0;
        bus.cmd_addr   = '0;
        bus.cmd_x0     = '0;
        bus.cmd_wid    = '0;
        bus.cmd_hgt    = '0;
        bus.cmd_color  = '0;
        bus.cmd_mode   = 1'b0;
        bus.arb_in_rtr = 1'b1;
        rst_ = 1'b1;
        #2 rst_ = 1'b0;
        #1 chk_idle_outputs("reset");
        repeat (2) @(negedge clk);
        rst_ = 1'b1;

        // Single pixel fill.
        clear_all();
        add_word(16'h0100, 32'h0000000F);
        run_cmd(16'h0100, 3'd0, 16'd1, 16'd1, 1'b0, 0, 0, cyc);
        compare("fill1x1");
        chk("fill1x1.cycles", 32'(cyc), 32'd3);

        // Two-word, two-row fill starting mid-word.
        clear_all();
        add_word(16'h0100, 32'hFF000000);
        add_word(16'h0103, 32'hFFFFFFFF);
        add_word(16'h01F0, 32'hFF000000);
        add_word(16'h01F3, 32'hFFFFFFFF);
        run_cmd(16'h0100, 3'd6, 16'd10, 16'd2, 1'b0, 0, 0, cyc);
        compare("fill10x2");
        chk("fill10x2.cycles", 32'(cyc), 32'd12);

        // Same command with three stalled cycles after the second write.
        g_addr.delete(); g_bm.delete(); g_dat.delete(); g_wb.delete();
        run_cmd(16'h0100, 3'd6, 16'd10, 16'd2, 1'b0, 3, 0, cyc);
        compare("stall");
        chk("stall.cycles", 32'(cyc), 32'd15);

        // Outline: middle row touches only the edge pixels.
        clear_all();
        add_word(16'h0100, 32'hFFFFFFFF);
        add_word(16'h0103, 32'hFFFFFFFF);
        add_word(16'h01F0, 32'h0000000F);
        add_word(16'h01F3, 32'hF0000000);
        add_word(16'h02E0, 32'hFFFFFFFF);
        add_word(16'h02E3, 32'hFFFFFFFF);
        run_cmd(16'h0100, 3'd0, 16'd16, 16'd3, 1'b1, 0, 0, cyc);
        compare("outline16x3");

        // Zero width: consumed with no writes.
        clear_all();
        run_cmd(16'h0100, 3'd0, 16'd0, 16'd5, 1'b0, 0, 0, cyc);
        compare("wid0");
        chk("wid0.cycles", 32'(cyc), 32'd0);
        chk("wid0.rts", 32'(bus.arb_out_rts), 32'd0);

        // Reset while row 1 is being written.
        clear_all();
        run_cmd(16'h0100, 3'd6, 16'd10, 16'd2, 1'b0, 0, 8, cyc);
        chk("abort.progress", 32'(g_addr.size()), 32'd8);
        rst_ = 1'b0;
        #1 chk_idle_outputs("midreset");
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("postreset[%0d].rts", k), 32'(bus.arb_out_rts), 32'd0);
        end
        clear_all();
        add_word(16'h0200, 32'h0000000F);
        run_cmd(16'h0200, 3'd0, 16'd1, 16'd1, 1'b0, 0, 0, cyc);
        compare("fresh");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
